dot_product_accumulator: RTL

//  Consumes the product stream (P, done) of the array multiplier and sums every LEN

---
 rtl/mult_pkg.sv | 25 ++
 rtl/dot_product_accumulator_if.sv | 38 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/dot_product_accumulator.sv | 102 ++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ============================================================================
// Module : mult_pkg
// Brief  : Shared widths and types for the array multiplier datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int MULT_WIDTH = 8;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // Wide enough that len maximal products can never wrap.
    function automatic int acc_width(input int w, input int len);
        return prod_w(w) + $clog2(len);
    endfunction

    typedef logic [prod_w(MULT_WIDTH)-1:0] product_t;

endpackage

`default_nettype wire

// File: rtl/dot_product_accumulator_if.sv
// ============================================================================
// Module : dot_product_accumulator_if
// Brief  : Product input stream and result handshake of the accumulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dot_product_accumulator_if
    import mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LEN       = 16,
    parameter int ACC_WIDTH = acc_width(WIDTH, LEN)
);
    localparam int IDX_W = $clog2(LEN + 1);

    logic [prod_w(WIDTH)-1:0] P;
    logic                     done;
    logic                     clear;
    logic [ACC_WIDTH-1:0]     sum;
    logic                     sum_valid;
    logic                     sum_ready;
    logic [IDX_W-1:0]         elem_idx;
    logic                     overflow;

    modport master (
        output P, done, clear, sum_ready,
        input  sum, sum_valid, elem_idx, overflow
    );

    modport slave (
        input  P, done, clear, sum_ready,
        output sum, sum_valid, elem_idx, overflow
    );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO, power-of-two depth, push accepted when full if
//          a pop happens in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]  r_wr_ptr;
    logic [ADDR_W:0]  r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty differ.
    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign count    = CNT_W'(r_wr_ptr - r_rd_ptr);
    assign pop_data = r_mem[r_rd_ptr[ADDR_W-1:0]];

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dot_product_accumulator.sv
// ============================================================================
// Module : dot_product_accumulator
// Brief  : Sums every LEN products into one result and queues results for a
//          valid/ready consumer; results that find the queue full are dropped.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dot_product_accumulator
    import mult_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LEN        = 16,
    parameter int ACC_WIDTH  = acc_width(WIDTH, LEN),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    dot_product_accumulator_if.slave  bus
);
    localparam int                IDX_W    = $clog2(LEN + 1);
    localparam int                CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LEN - 1);

    if (LEN < 1) begin : g_bad_len
        $error("dot_product_accumulator: LEN must be at least 1");
    end
    if (ACC_WIDTH < acc_width(WIDTH, LEN)) begin : g_bad_acc
        $error("dot_product_accumulator: ACC_WIDTH too narrow for LEN products");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("dot_product_accumulator: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [ACC_WIDTH-1:0] r_acc;
    logic [IDX_W-1:0]     r_elem_idx;
    logic                 r_overflow;
    logic [ACC_WIDTH-1:0] w_next_sum;
    logic                 w_last;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [ACC_WIDTH-1:0] w_fifo_head;
    logic [CNT_W-1:0]     w_unused_fifo_count;

    assign w_next_sum = r_acc + ACC_WIDTH'(bus.P);
    assign w_last     = (r_elem_idx == LAST_IDX);
    // A clear in the same cycle as the closing product aborts the group.
    assign w_push     = bus.done && !bus.clear && w_last;
    assign w_pop      = bus.sum_valid && bus.sum_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc      <= '0;
            r_elem_idx <= '0;
        end else if (bus.clear) begin
            r_acc      <= '0;
            r_elem_idx <= '0;
        end else if (bus.done) begin
            if (w_last) begin
                r_acc      <= '0;
                r_elem_idx <= '0;
            end else begin
                r_acc      <= w_next_sum;
                r_elem_idx <= r_elem_idx + 1'b1;
            end
        end
    end

    // A pop in the same cycle frees the slot, so only push-without-pop drops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ACC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_next_sum),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_unused_fifo_count)
    );

    assign bus.sum       = w_fifo_head;
    assign bus.sum_valid = !w_fifo_empty;
    assign bus.elem_idx  = r_elem_idx;
    assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire
